// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with a valid/ready handshake,
// a 2-entry skid buffer, ctrl stall obedience and single-cycle flush.
//
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   stall_sign[STALL_W]            ctrl stall vector, bit STALL_IDX freezes
//   flush                          squash every held entry on the next edge
//   in_valid/in_ready              upstream handshake
//   in_payload/in_wd/in_wreg       upstream entry
//   out_valid/out_ready            downstream handshake
//   out_payload/out_wd/out_wreg    head entry (all zero while out_valid = 0)
//
// Optional feature, macro PIPE_STAGE_PERF_EN:
//   stall_cnt[CNT_W]   cycles spent stalled with a valid head
//   bubble_cnt[CNT_W]  cycles out of reset with no valid head
//   Both wrap and are cleared by reset only.

module pipe_stage_buf #(
    parameter int PAYLOAD_W  = 104,
    parameter int REG_ADDR_W = 5,
    parameter int STALL_W    = 6,
    parameter int STALL_IDX  = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall_sign,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    input  logic [REG_ADDR_W-1:0] in_wd,
    input  logic                  in_wreg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAYLOAD_W-1:0]  out_payload,
    output logic [REG_ADDR_W-1:0] out_wd,
    output logic                  out_wreg
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
`endif
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0]  payload;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state;
    entry_t r_main;
    entry_t r_skid;

    logic   w_stl;
    logic   w_in_fire;
    logic   w_out_fire;
    entry_t w_in;
    logic   w_stall_unused;

    assign w_stl = stall_sign[STALL_IDX];
    assign w_stall_unused = ^stall_sign;

    assign w_in.payload = in_payload;
    assign w_in.wd      = in_wd;
    assign w_in.wreg    = in_wreg;

    // Ready depends on registered state and ctrl inputs only, never on
    // out_ready, so no combinational path crosses the stage.
    assign in_ready = (r_state != S_FULL) & ~w_stl & ~flush & rst;

    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready & ~w_stl;

    // r_main is kept zero whenever the buffer is empty, so the head
    // fields come straight from the register and bubbles never write.
    assign out_payload = r_main.payload;
    assign out_wd      = r_main.wd;
    assign out_wreg    = r_main.wreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (!w_stl) begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= w_in;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_in;
                    end else if (w_in_fire) begin
                        r_skid  <= w_in;
                        r_state <= S_FULL;
                    end else if (w_out_fire) begin
                        r_main  <= '0;
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // Skid is always the younger entry; it moves up.
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_skid  <= '0;
                        r_state <= S_ONE;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_main  <= '0;
                    r_skid  <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (w_stl && out_valid) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!out_valid) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`else
    localparam int W_CNT_UNUSED = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for pipe_stage_buf.
// Queue-based reference model, directed scenarios then random traffic.

module tb_pipe_stage_buf;

    localparam int PW = 104;
    localparam int RW = 5;
    localparam int SW = 6;
    localparam int SI = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [SW-1:0] stall_sign = '0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_payload = '0;
    logic [RW-1:0] in_wd = '0;
    logic          in_wreg = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_payload;
    logic [RW-1:0] out_wd;
    logic          out_wreg;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
    int unsigned   m_stall = 0;
    int unsigned   m_bubble = 0;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk         (clk),
        .rst         (rst),
        .stall_sign  (stall_sign),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_wd       (in_wd),
        .in_wreg     (in_wreg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_wd      (out_wd),
        .out_wreg    (out_wreg)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    typedef struct {
        logic [PW-1:0] p;
        logic [RW-1:0] wd;
        logic          wr;
    } ent_t;

    // Model: contents of the stage in arrival order, oldest first.
    ent_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // One driven cycle: inputs change on the falling edge, ready is
    // checked against the model, then the model absorbs the cycle.
    task automatic cyc(input bit v, input logic [PW-1:0] p,
                       input logic [RW-1:0] wd, input bit wr,
                       input bit ordy, input bit st, input bit fl);
        bit mrdy;
        @(negedge clk);
        in_valid   = v;
        in_payload = p;
        in_wd      = wd;
        in_wreg    = wr;
        out_ready  = ordy;
        stall_sign = SW'($urandom);
        stall_sign[SI] = st;
        flush      = fl;
        #1;
        mrdy = (q.size() < 2) && !st && !fl && (rst == 1'b1);
        chk("in_ready", 128'(in_ready), 128'(mrdy));
        #2;
        if (fl) q.delete();
        else if (v && mrdy) q.push_back('{p, wd, wr});
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, ordy, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_payload", 128'(out_payload), 128'(0));
        chk("rst_out_wd", 128'(out_wd), 128'(0));
        chk("rst_out_wreg", 128'(out_wreg), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        q.delete();
`ifdef PIPE_STAGE_PERF_EN
        m_stall = 0;
        m_bubble = 0;
`endif
        idle(2, 1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compare the presented head against the model each cycle,
    // pop on a completed downstream transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
`ifdef PIPE_STAGE_PERF_EN
                chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
                chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
                if (q.size() == 0) m_bubble++;
                else if (stall_sign[SI]) m_stall++;
`endif
                chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
                if (q.size() == 0) begin
                    chk("bubble_payload", 128'(out_payload), 128'(0));
                    chk("bubble_wd", 128'(out_wd), 128'(0));
                    chk("bubble_wreg", 128'(out_wreg), 128'(0));
                end else begin
                    chk("out_payload", 128'(out_payload), 128'(q[0].p));
                    chk("out_wd", 128'(out_wd), 128'(q[0].wd));
                    chk("out_wreg", 128'(out_wreg), 128'(q[0].wr));
                    if (out_ready && !stall_sign[SI] && !flush)
                        void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [127:0] r;
        bit st, fl;

        // Reset held from time 0.
        idle(2, 1);
        chk("init_out_valid", 128'(out_valid), 128'(0));
        chk("init_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b1;

        // Single entry then back-to-back stream.
        for (int i = 0; i < 8; i++)
            cyc(1, PW'(8'h11 + i), RW'(5 + i), 1, 1, 0, 0);
        idle(3, 1);

        // Fill to FULL, then drain.
        cyc(1, PW'(8'hA1), 5'd1, 1, 0, 0, 0);
        cyc(1, PW'(8'hA2), 5'd2, 0, 0, 0, 0);
        cyc(1, PW'(8'hAF), 5'd3, 1, 0, 0, 0);
        idle(4, 1);

        // Stall holds the head.
        cyc(1, PW'(8'hB1), 5'd7, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, PW'(8'hBF), 5'd8, 1, 1, 1, 0);
        idle(3, 1);

        // Flush beats stall and a simultaneous offer.
        cyc(1, PW'(8'hC1), 5'd9, 1, 0, 0, 0);
        cyc(1, PW'(8'hC2), 5'd10, 1, 0, 0, 0);
        cyc(1, PW'(8'hC3), 5'd11, 1, 1, 1, 1);
        idle(3, 1);

        // Reset with two entries held.
        cyc(1, PW'(8'hE1), 5'd12, 1, 0, 0, 0);
        cyc(1, PW'(8'hE2), 5'd13, 1, 0, 0, 0);
        apply_reset();
        cyc(1, PW'(8'hD1), 5'd14, 1, 1, 0, 0);
        idle(3, 1);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            st = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 19) == 0);
            cyc(($urandom_range(0, 9) < 7), r[PW-1:0], RW'($urandom),
                1'($urandom), ($urandom_range(0, 9) < 6), st, fl);
        end
        idle(4, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
